// File: rtl/hop_latency_checker.sv
`default_nettype none
// ============================================================================
// Module      : hop_latency_checker
// Description : Closed-loop launch/capture stage for a single-bit hop chain.
//               Launches a one-cycle start pulse into the chain head and
//               measures the cycles until the pulse arrives at the chain tail.
//               It then checks the latency against EXP_LAT and checks that the
//               arriving pulse is one cycle wide. Saturating run and error
//               counters let hop benchmarks self-check in hardware.
// Revision    : 1.0 - initial release
// ============================================================================
module hop_latency_checker #(
    parameter int EXP_LAT = 5,   // expected launch-to-arrival latency (cycles)
    parameter int TIMEOUT = 31,  // WAIT cycles before declaring no arrival
    parameter int CNT_W   = 5,   // latency counter width
    parameter int GAP     = 4,   // idle cycles between runs (>= 1)
    parameter int STAT_W  = 8    // run / error counter width
) (
    input  logic              clock0,
    input  logic              rst1,
    input  logic              enable,
    input  logic              chain_in,
    output logic              start,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  lat,
    output logic [STAT_W-1:0] run_cnt,
    output logic [STAT_W-1:0] err_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_WAIT   = 2'd1;
    localparam logic [1:0] c_S_CHECKW = 2'd2;
    localparam logic [1:0] c_S_GAP    = 2'd3;

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_LATENCY = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] c_ERR_WIDTH   = 2'd3;

    localparam logic [CNT_W-1:0]  c_EXP_LAT  = CNT_W'(EXP_LAT);
    localparam logic [CNT_W-1:0]  c_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_LAT_ONES = '1;
    localparam logic [STAT_W-1:0] c_STAT_MAX = '1;

    // The gap counter only needs to reach GAP-1.
    localparam int                 c_GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP - 1);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [c_GAP_W-1:0] r_gcnt;
    logic               r_start;
    logic               r_busy;
    logic               r_pass;
    logic               r_fail;
    logic [1:0]         r_err_code;
    logic [CNT_W-1:0]   r_lat;
    logic [STAT_W-1:0]  r_run_cnt;
    logic [STAT_W-1:0]  r_err_cnt;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [c_GAP_W-1:0] w_gcnt_nxt;
    logic               w_start_nxt;
    logic               w_verdict;      // a run ends on this edge
    logic               w_verdict_fail; // ... and that run failed
    logic [1:0]         w_err_code_nxt;
    logic [CNT_W-1:0]   w_lat_nxt;
    logic [STAT_W-1:0]  w_run_cnt_nxt;
    logic [STAT_W-1:0]  w_err_cnt_nxt;

    // FSM transitions, latency capture and the verdict decision
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_gcnt_nxt     = r_gcnt;
        w_start_nxt    = 1'b0;
        w_verdict      = 1'b0;
        w_verdict_fail = 1'b0;
        w_err_code_nxt = r_err_code;
        w_lat_nxt      = r_lat;

        case (r_state)
            c_S_IDLE: begin
                if (enable) begin
                    if (chain_in) begin
                        // Tail already high before any launch: the chain is
                        // stuck, so report it and skip the launch.
                        w_verdict      = 1'b1;
                        w_verdict_fail = 1'b1;
                        w_err_code_nxt = c_ERR_WIDTH;
                        w_lat_nxt      = '0;
                        w_gcnt_nxt     = '0;
                        w_state_nxt    = c_S_GAP;
                    end else begin
                        w_start_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = c_S_WAIT;
                    end
                end
            end

            c_S_WAIT: begin
                if (chain_in) begin
                    // cnt equals k when the pulse is first sampled at Ek+1
                    w_lat_nxt   = r_cnt;
                    w_state_nxt = c_S_CHECKW;
                end else if (r_cnt == c_TIMEOUT) begin
                    w_verdict      = 1'b1;
                    w_verdict_fail = 1'b1;
                    w_err_code_nxt = c_ERR_TIMEOUT;
                    w_lat_nxt      = c_LAT_ONES;
                    w_gcnt_nxt     = '0;
                    w_state_nxt    = c_S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            c_S_CHECKW: begin
                // The arriving pulse must already have dropped on this edge.
                w_verdict = 1'b1;
                if (chain_in) begin
                    w_verdict_fail = 1'b1;
                    w_err_code_nxt = c_ERR_WIDTH;
                end else if (r_lat == c_EXP_LAT) begin
                    w_err_code_nxt = c_ERR_NONE;
                end else begin
                    w_verdict_fail = 1'b1;
                    w_err_code_nxt = c_ERR_LATENCY;
                end
                w_gcnt_nxt  = '0;
                w_state_nxt = c_S_GAP;
            end

            c_S_GAP: begin
                if (r_gcnt == c_GAP_LAST) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_gcnt_nxt = r_gcnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Saturating statistics: every verdict is a run, every fail an error
    always_comb begin
        w_run_cnt_nxt = r_run_cnt;
        w_err_cnt_nxt = r_err_cnt;
        if (w_verdict && (r_run_cnt != c_STAT_MAX)) begin
            w_run_cnt_nxt = r_run_cnt + 1'b1;
        end
        if (w_verdict && w_verdict_fail && (r_err_cnt != c_STAT_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    // Register all state and outputs; reset clears everything immediately
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_err_code <= c_ERR_NONE;
            r_lat      <= '0;
            r_run_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gcnt     <= w_gcnt_nxt;
            r_start    <= w_start_nxt;
            r_busy     <= (w_state_nxt != c_S_IDLE);
            r_pass     <= w_verdict & ~w_verdict_fail;
            r_fail     <= w_verdict & w_verdict_fail;
            r_err_code <= w_err_code_nxt;
            r_lat      <= w_lat_nxt;
            r_run_cnt  <= w_run_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign start    = r_start;
    assign busy     = r_busy;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign err_code = r_err_code;
    assign lat      = r_lat;
    assign run_cnt  = r_run_cnt;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hop_latency_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_hop_latency_checker
// Description : Directed bench for hop_latency_checker. A behavioural shift
//               register stands in for the hop chain; the mode variable picks
//               which tap (or constant) feeds chain_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hop_latency_checker;

    localparam int c_M5    = 0;  // ideal 5-flop chain
    localparam int c_M6    = 1;  // 6-flop chain
    localparam int c_TIE0  = 2;  // tail tied low
    localparam int c_TIE1  = 3;  // tail tied high
    localparam int c_PULS2 = 4;  // 2-cycle pulse arriving at latency 5

    logic       clock0;
    logic       rst1;
    logic       enable;
    logic       chain_in;
    logic       start;
    logic       busy;
    logic       pass;
    logic       fail;
    logic [1:0] err_code;
    logic [4:0] lat;
    logic [7:0] run_cnt;
    logic [7:0] err_cnt;

    logic [7:0] r_sr;
    int         mode;
    int         n_cmp;
    int         n_err;

    hop_latency_checker #(
        .EXP_LAT (5),
        .TIMEOUT (31),
        .CNT_W   (5),
        .GAP     (4),
        .STAT_W  (8)
    ) dut (
        .clock0   (clock0),
        .rst1     (rst1),
        .enable   (enable),
        .chain_in (chain_in),
        .start    (start),
        .busy     (busy),
        .pass     (pass),
        .fail     (fail),
        .err_code (err_code),
        .lat      (lat),
        .run_cnt  (run_cnt),
        .err_cnt  (err_cnt)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    // Hop chain model: each stage is one flop fed by the start pulse
    always @(posedge clock0 or posedge rst1) begin
        if (rst1) r_sr <= '0;
        else      r_sr <= {r_sr[6:0], start};
    end

    // Tail selection
    always_comb begin
        chain_in = 1'b0;
        case (mode)
            c_M5:    chain_in = r_sr[4];
            c_M6:    chain_in = r_sr[5];
            c_TIE0:  chain_in = 1'b0;
            c_TIE1:  chain_in = 1'b1;
            default: chain_in = r_sr[4] | r_sr[5];
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clock0);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst1   = 1'b1;
        enable = 1'b0;
        mode   = c_M5;

        // ---------------- reset state ----------------
        tick(2);
        chk("rst_start",   32'(start),    0);
        chk("rst_busy",    32'(busy),     0);
        chk("rst_pass",    32'(pass),     0);
        chk("rst_fail",    32'(fail),     0);
        chk("rst_errcode", 32'(err_code), 0);
        chk("rst_lat",     32'(lat),      0);
        chk("rst_runcnt",  32'(run_cnt),  0);
        chk("rst_errcnt",  32'(err_cnt),  0);
        rst1   = 1'b0;
        enable = 1'b1;

        // ---------------- 5-flop chain: pass ----------------
        tick(1);                               // E0
        chk("t1_start_e0", 32'(start), 1);
        chk("t1_busy_e0",  32'(busy),  1);
        tick(1);                               // E1
        chk("t1_start_e1", 32'(start), 0);
        tick(5);                               // E6: arrival sampled
        chk("t1_pass_e6",  32'(pass),  0);
        tick(1);                               // E7: verdict
        chk("t1_pass",     32'(pass),     1);
        chk("t1_fail",     32'(fail),     0);
        chk("t1_errcode",  32'(err_code), 0);
        chk("t1_lat",      32'(lat),      5);
        chk("t1_runcnt",   32'(run_cnt),  1);
        chk("t1_errcnt",   32'(err_cnt),  0);
        tick(1);                               // E8
        chk("t1_pass_e8",  32'(pass),  0);
        tick(3);                               // E11: back to IDLE
        chk("t1_busy_e11", 32'(busy),  0);
        chk("t1_start_e11",32'(start), 0);
        tick(1);                               // E12: next launch
        chk("t1_start_e12",32'(start), 1);

        // ---------------- 6-flop chain: latency mismatch ----------------
        mode = c_M6;
        tick(8);                               // E20: verdict
        chk("t2_fail",     32'(fail),     1);
        chk("t2_pass",     32'(pass),     0);
        chk("t2_errcode",  32'(err_code), 1);
        chk("t2_lat",      32'(lat),      6);
        chk("t2_runcnt",   32'(run_cnt),  2);
        chk("t2_errcnt",   32'(err_cnt),  1);
        enable = 1'b0;
        tick(4);                               // E24: parked
        chk("t2_busy_park",32'(busy), 0);
        tick(3);
        chk("t2_start_park",32'(start), 0);
        chk("t2_runcnt_park",32'(run_cnt), 2);

        // ---------------- tail tied low: timeout ----------------
        mode   = c_TIE0;
        enable = 1'b1;
        tick(1);                               // F0
        chk("t3_start_f0", 32'(start), 1);
        enable = 1'b0;                         // run must still complete
        tick(1);                               // F1
        chk("t3_busy_f1",  32'(busy), 1);
        tick(30);                              // F31
        chk("t3_busy_f31", 32'(busy), 1);
        chk("t3_fail_f31", 32'(fail), 0);
        tick(1);                               // F32: timeout verdict
        chk("t3_fail",     32'(fail),     1);
        chk("t3_errcode",  32'(err_code), 2);
        chk("t3_lat",      32'(lat),      31);
        chk("t3_runcnt",   32'(run_cnt),  3);
        chk("t3_errcnt",   32'(err_cnt),  2);
        tick(1);                               // F33
        chk("t3_fail_f33", 32'(fail),     0);
        chk("t3_hold_ec",  32'(err_code), 2);
        tick(3);                               // F36: IDLE
        chk("t3_busy_f36", 32'(busy), 0);

        // ---------------- tail stuck high: no launch ----------------
        mode   = c_TIE1;
        enable = 1'b1;
        tick(1);                               // G0
        chk("t4_start",    32'(start),    0);
        chk("t4_fail",     32'(fail),     1);
        chk("t4_errcode",  32'(err_code), 3);
        chk("t4_lat",      32'(lat),      0);
        chk("t4_runcnt",   32'(run_cnt),  4);
        chk("t4_errcnt",   32'(err_cnt),  3);
        enable = 1'b0;
        tick(1);
        chk("t4_fail_g1",  32'(fail), 0);
        tick(4);
        chk("t4_busy_park",32'(busy), 0);

        // ---------------- 2-cycle pulse: width error ----------------
        mode   = c_PULS2;
        enable = 1'b1;
        tick(1);                               // H0
        chk("t5_start",    32'(start), 1);
        enable = 1'b0;
        tick(6);                               // H6
        chk("t5_fail_h6",  32'(fail), 0);
        tick(1);                               // H7
        chk("t5_fail",     32'(fail),     1);
        chk("t5_errcode",  32'(err_code), 3);
        chk("t5_lat",      32'(lat),      5);
        chk("t5_runcnt",   32'(run_cnt),  5);
        chk("t5_errcnt",   32'(err_cnt),  4);
        tick(5);

        // ---------------- async reset mid-run ----------------
        mode   = c_M5;
        enable = 1'b1;
        tick(1);                               // J0
        chk("t6_start_j0", 32'(start), 1);
        enable = 1'b0;
        tick(3);                               // J3
        chk("t6_busy_j3",  32'(busy), 1);
        #2 rst1 = 1'b1;
        #1;
        chk("t6_rst_busy",    32'(busy),     0);
        chk("t6_rst_errcode", 32'(err_code), 0);
        chk("t6_rst_lat",     32'(lat),      0);
        chk("t6_rst_runcnt",  32'(run_cnt),  0);
        chk("t6_rst_errcnt",  32'(err_cnt),  0);
        #2 rst1 = 1'b0;
        tick(10);
        chk("t6_noverdict_p", 32'(pass),    0);
        chk("t6_noverdict_f", 32'(fail),    0);
        chk("t6_runcnt_idle", 32'(run_cnt), 0);
        enable = 1'b1;
        tick(1);                               // K0
        chk("t6_start_k0", 32'(start), 1);
        tick(7);                               // K7
        chk("t6_pass",     32'(pass),    1);
        chk("t6_lat",      32'(lat),     5);
        chk("t6_runcnt",   32'(run_cnt), 1);

        // ---------------- saturation: 300 passing runs ----------------
        tick(12 * 253);                        // run 254 verdict
        chk("t7_run254",   32'(run_cnt), 254);
        tick(12);                              // run 255
        chk("t7_run255",   32'(run_cnt), 255);
        tick(12);                              // run 256: no wrap
        chk("t7_pass256",  32'(pass),    1);
        chk("t7_sat256",   32'(run_cnt), 255);
        tick(12 * 44);                         // run 300
        chk("t7_pass300",  32'(pass),    1);
        chk("t7_sat300",   32'(run_cnt), 255);
        chk("t7_errcnt",   32'(err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
